// File: rtl/core_pkg.sv
// Shared RS/issue types for the select stage.
// Oldest-first select is enabled by defining ISSUE_AGE_SEL_EN.
package core_pkg;

    localparam int RS_ENTRIES = 8;
    localparam int RS_IDX_W   = $clog2(RS_ENTRIES);

    typedef logic [RS_IDX_W-1:0] rs_idx_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic    valid;
        rs_idx_t entry;
    } issue_slot_t;

endpackage

// File: rtl/age_matrix.sv
// NxN allocation-order matrix: older_q[i][j]=1 means i was allocated before j.
// Reports, per entry, whether an older eligible requester exists.
module age_matrix
    import core_pkg::*;
#(
    parameter int N_ENTRIES = RS_ENTRIES,
    parameter int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_ok,
    input  logic [IDX_W-1:0]     alloc_entry,
    input  logic                 release_ok,
    input  logic [IDX_W-1:0]     release_entry,
    input  logic [N_ENTRIES-1:0] mask_rel,
    input  logic [N_ENTRIES-1:0] elig,
    output logic [N_ENTRIES-1:0] older_req
);

    logic [N_ENTRIES-1:0] older_q [N_ENTRIES];
    logic [N_ENTRIES-1:0] older_d [N_ENTRIES];

    always_comb begin
        older_d = older_q;
        if (release_ok) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                older_d[release_entry][i] = 1'b0;
                older_d[i][release_entry] = 1'b0;
            end
        end
        // Uses the post-release mask so a same-cycle re-alloc becomes youngest.
        if (alloc_ok) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                older_d[alloc_entry][i] = 1'b0;
                if (i != int'(alloc_entry))
                    older_d[i][alloc_entry] = mask_rel[i];
            end
        end
    end

    always_comb begin
        older_req = '0;
        for (int i = 0; i < N_ENTRIES; i++)
            for (int j = 0; j < N_ENTRIES; j++)
                older_req[i] = older_req[i] | (elig[j] & older_q[j][i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++)
                older_q[i] <= '0;
        end else begin
            older_q <= older_d;
        end
    end

endmodule

// File: rtl/issue_select.sv
// RS select stage: picks one eligible entry and holds it in a one-deep issue slot.
// ISSUE_AGE_SEL_EN selects oldest-first; otherwise lowest index wins.
module issue_select
    import core_pkg::*;
#(
    parameter int N_ENTRIES = RS_ENTRIES,
    parameter int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_valid,
    input  logic [IDX_W-1:0]     alloc_entry,
    input  logic                 release_valid,
    input  logic [IDX_W-1:0]     release_entry,
    input  logic [N_ENTRIES-1:0] reqs,
    output logic [IDX_W-1:0]     grant,
    output logic                 grant_valid,
    output logic                 issue_valid,
    output logic [IDX_W-1:0]     issue_entry,
    input  logic                 issue_ready
);

    logic [N_ENTRIES-1:0] alloc_mask;
    logic [N_ENTRIES-1:0] mask_rel;
    logic [N_ENTRIES-1:0] elig;
    logic [N_ENTRIES-1:0] older_req;
    logic [N_ENTRIES-1:0] win;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     grant_q;
    logic                 release_ok;
    logic                 alloc_ok;
    logic                 slot_free;
    slot_state_e          state;
    issue_slot_t          slot;

    assign release_ok = release_valid & alloc_mask[release_entry];
    assign mask_rel   = release_ok ? alloc_mask & ~(N_ENTRIES'(1) << release_entry)
                                   : alloc_mask;
    assign alloc_ok   = alloc_valid & ~mask_rel[alloc_entry];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            alloc_mask <= '0;
        else if (alloc_ok)
            alloc_mask <= mask_rel | (N_ENTRIES'(1) << alloc_entry);
        else
            alloc_mask <= mask_rel;
    end

    assign elig = reqs & alloc_mask;

`ifdef ISSUE_AGE_SEL_EN
    age_matrix #(
        .N_ENTRIES (N_ENTRIES),
        .IDX_W     (IDX_W)
    ) u_age (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_ok      (alloc_ok),
        .alloc_entry   (alloc_entry),
        .release_ok    (release_ok),
        .release_entry (release_entry),
        .mask_rel      (mask_rel),
        .elig          (elig),
        .older_req     (older_req)
    );
`else
    assign older_req = '0;
`endif

    assign win = elig & ~older_req;

    always_comb begin
        win_idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--)
            if (win[i])
                win_idx = IDX_W'(i);
    end

    assign slot_free   = ~slot.valid | issue_ready;
    assign grant_valid = (|elig) & slot_free;
    assign grant       = grant_valid ? win_idx : grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SLOT_EMPTY;
            slot    <= '0;
            grant_q <= '0;
        end else begin
            if (grant_valid)
                grant_q <= win_idx;
            unique case (state)
                SLOT_EMPTY: begin
                    if (grant_valid) begin
                        state <= SLOT_FULL;
                        slot  <= '{valid: 1'b1, entry: rs_idx_t'(win_idx)};
                    end
                end
                SLOT_FULL: begin
                    if (issue_ready && grant_valid) begin
                        slot.entry <= rs_idx_t'(win_idx);
                    end else if (issue_ready) begin
                        state      <= SLOT_EMPTY;
                        slot.valid <= 1'b0;
                    end
                end
                default: begin
                    state <= SLOT_EMPTY;
                    slot  <= '0;
                end
            endcase
        end
    end

    assign issue_valid = slot.valid;
    assign issue_entry = IDX_W'(slot.entry);

    a_alloc_legal: assert property (@(posedge clk) disable iff (!rst_n)
        alloc_valid |-> ~mask_rel[alloc_entry]);
    a_release_legal: assert property (@(posedge clk) disable iff (!rst_n)
        release_valid |-> alloc_mask[release_entry]);

endmodule

// File: tb/tb_issue_select.sv
// Scoreboard bench for issue_select: grants are queued at selection and
// checked by a monitor when the issue slot hands off downstream.
module tb_issue_select;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_valid;
    logic [2:0] alloc_entry;
    logic       release_valid;
    logic [2:0] release_entry;
    logic [7:0] reqs;
    logic [2:0] grant;
    logic       grant_valid;
    logic       issue_valid;
    logic [2:0] issue_entry;
    logic       issue_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_mask;
    int         m_ord[$];
    logic       m_full;
    int         m_entry;
    int         sb[$];

    always #5 clk = ~clk;

    issue_select dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_valid   (alloc_valid),
        .alloc_entry   (alloc_entry),
        .release_valid (release_valid),
        .release_entry (release_entry),
        .reqs          (reqs),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .issue_valid   (issue_valid),
        .issue_entry   (issue_entry),
        .issue_ready   (issue_ready)
    );

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    function automatic int exp_grant(input logic [7:0] r);
        logic [7:0] e;
        e = r & m_mask;
`ifdef ISSUE_AGE_SEL_EN
        foreach (m_ord[k])
            if (e[m_ord[k]])
                return m_ord[k];
`else
        for (int i = 0; i < 8; i++)
            if (e[i])
                return i;
`endif
        return 0;
    endfunction

    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_issue: got %0d expected none", issue_entry);
            end else begin
                int e;
                e = sb.pop_front();
                if (int'(issue_entry) != e) begin
                    errors++;
                    $display("FAIL sb_issue: got %0d expected %0d", issue_entry, e);
                end
            end
        end
    end

    task automatic model_clear();
        m_mask = '0;
        m_ord.delete();
        m_full = 1'b0;
        m_entry = 0;
        sb.delete();
    endtask

    task automatic step(input logic av, input int ae, input logic rv,
                        input int re, input logic [7:0] rq, input logic rd);
        logic e_gv;
        int   e_g;
        alloc_valid   = av;
        alloc_entry   = 3'(ae);
        release_valid = rv;
        release_entry = 3'(re);
        reqs          = rq;
        issue_ready   = rd;
        @(negedge clk);
        e_gv = (|(rq & m_mask)) && (!m_full || rd);
        e_g  = exp_grant(rq);
        chk("grant_valid", int'(grant_valid), int'(e_gv));
        if (e_gv) begin
            chk("grant", int'(grant), e_g);
            sb.push_back(e_g);
        end
        chk("issue_valid", int'(issue_valid), int'(m_full));
        if (m_full)
            chk("issue_entry", int'(issue_entry), m_entry);
        @(posedge clk);
        if (rv && m_mask[re]) begin
            m_mask[re] = 1'b0;
            foreach (m_ord[k])
                if (m_ord[k] == re) begin
                    m_ord.delete(k);
                    break;
                end
        end
        if (av && !m_mask[ae]) begin
            m_mask[ae] = 1'b1;
            m_ord.push_back(ae);
        end
        if (e_gv) begin
            m_full  = 1'b1;
            m_entry = e_g;
        end else if (rd) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_valid = 1'b0;
        alloc_entry = '0;
        release_valid = 1'b0;
        release_entry = '0;
        reqs = 8'hFF;
        issue_ready = 1'b1;
        model_clear();
        @(negedge clk);
        chk("rst_issue_valid", int'(issue_valid), 0);
        chk("rst_grant_valid", int'(grant_valid), 0);
        chk("rst_grant", int'(grant), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Allocation order 5, 2, 7
        step(1, 5, 0, 0, 8'h00, 0);
        step(1, 2, 0, 0, 8'h00, 0);
        step(1, 7, 0, 0, 8'h00, 0);
        step(0, 0, 0, 0, 8'b1010_0100, 1);
        step(0, 0, 0, 0, 8'b1000_0100, 1);
        step(0, 0, 0, 0, 8'b1000_0000, 1);

        // Backpressure: slot held for three cycles
        repeat (3) step(0, 0, 0, 0, 8'b1000_0100, 0);
        step(0, 0, 0, 0, 8'b1000_0100, 1);
        step(0, 0, 0, 0, 8'b1000_0000, 1);
        step(0, 0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 0, 8'h00, 1);

        // Release+alloc of 5 in one cycle makes it youngest
        step(1, 5, 1, 5, 8'h00, 1);
        step(0, 0, 0, 0, 8'b1010_0100, 1);
        step(0, 0, 0, 0, 8'b1010_0000, 1);
        step(0, 0, 0, 0, 8'h00, 0);

        // Releasing the slotted entry leaves the slot intact
        step(0, 0, 1, m_entry, 8'h00, 0);
        step(1, 3, 1, 2, 8'h00, 0);
        step(0, 0, 0, 0, 8'b0010_1000, 1);
        step(1, 1, 0, 0, 8'b0010_1010, 0);

        // Asynchronous reset while the slot is full
        chk("pre_rst_full", int'(issue_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_issue_valid", int'(issue_valid), 0);
        chk("async_grant_valid", int'(grant_valid), 0);
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0, 0, 8'hFF, 1);
        step(1, 1, 0, 0, 8'h00, 1);
        step(0, 0, 0, 0, 8'hFF, 1);
        step(0, 0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 0, 8'h00, 1);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
